hetic_arbiter: RTL and testbench
================================

Name: hetic_arbiter

Overview:
- Interrupt scheduler paired with the OBI HETI interrupt-line register file.
- Turns raw interrupt sources into pending-bit set requests, using each line's trigger mode.
- Picks the highest-priority enabled pending line above the core's current threshold and presents it to the core with the line's heti/nest attributes.
- On core acknowledge, issues a pending-clear back to the register file.

Parameters:
- NrIrqLines, 64, number of interrupt lines.
- NrIrqPrios, 32, number of priority levels.
- IrqWidth, $clog2(NrIrqLines), derived (localparam).
- PrioWidth, $clog2(NrIrqPrios), derived (localparam).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- irq_src_i  in  NrIrqLines  raw sources, synchronous to clk_i.
- cfg_ie_i  in  NrIrqLines  per-line enable.
- cfg_ip_i  in  NrIrqLines  per-line pending (registered in the register file).
- cfg_trig_i  in  2*NrIrqLines  per-line trigger mode.
- cfg_heti_i  in  NrIrqLines  per-line HETI attribute.
- cfg_nest_i  in  NrIrqLines  per-line nesting attribute.
- cfg_prio_i  in  PrioWidth*NrIrqLines  per-line priority.
- threshold_i  in  PrioWidth  core's current interrupt level.
- ip_set_o  out  NrIrqLines  one-cycle pending-set strobes.
- ip_clr_o  out  NrIrqLines  one-cycle pending-clear strobe.
- irq_valid_o  out  1  request to core.
- irq_id_o  out  IrqWidth  presented line.
- irq_prio_o  out  PrioWidth  presented priority.
- irq_heti_o  out  1  presented HETI attribute.
- irq_nest_o  out  1  presented nesting attribute.
- irq_ack_i  in  1  core acknowledge.
- irq_ack_id_i  in  IrqWidth  id being acknowledged.

Behaviour:
- Reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i. All flops clear and all outputs are 0; FSM state is IDLE; the source-history register is 0.
- Trigger modes (per cfg_trig_i line field):
  - 00: level-high; ip_set_o[i] = src[i] on every cycle.
  - 01: rising edge; ip_set_o[i] = src & ~src_q.
  - 10: falling edge; ip_set_o[i] = ~src & src_q.
  - 11: both edges; ip_set_o[i] = src ^ src_q.
  - ip_set_o is combinational from irq_src_i and src_q. src_q is the previous-cycle source.
- Candidates: cand[i] = cfg_ie_i[i] & cfg_ip_i[i] & (cfg_prio_i[i] > threshold_i).
  - Priority 0 is never taken.
  - The comparison is unsigned at PrioWidth.
- Selection:
  - Combinational tournament tree; highest prio wins; on a tie the lower index wins.
  - Winner {valid, id, prio} is registered in best_q, giving 1 cycle of latency.
- FSM states:
  - IDLE: if best_q.valid, move to REQ and latch best_q into the output registers.
  - REQ:
    - irq_valid_o = 1; id, prio, heti and nest are held stable.
    - If irq_ack_i and irq_ack_id_i == irq_id_o: pulse ip_clr_o[irq_id_o] this cycle, go to SETTLE.
    - Else, if best_q.valid and best_q.prio > irq_prio_o (strictly higher): re-latch outputs from best_q and stay in REQ (pre-emption before ack).
    - Else, if ~best_q.valid (line disabled, cleared by software, or threshold raised): drop to IDLE; irq_valid_o falls next cycle.
    - An ack with a mismatched id is ignored.
  - SETTLE:
    - irq_valid_o = 0 for 2 cycles, so the cleared ip propagates through the register file and best_q.
    - Then go to IDLE.
- Latency: ip rises in cycle t, best_q is valid in t+1, irq_valid_o is high in t+2.
- Heti/nest: sampled from cfg at latch time. Config changes while in REQ do not alter the presented attributes unless a re-latch occurs.
- Simultaneous events:
  - Ack wins over pre-emption.
  - An ip_set and ip_clr on the same line in the same cycle are both driven. The register file resolves this with set priority, so a level source that is still high re-pends.
- Reset mid-REQ: irq_valid_o drops asynchronously and no clear is issued.

Decomposition:
- hetic_pkg holds:
  - trig_e (LEVEL = 2'b00, RISE = 2'b01, FALL = 2'b10, BOTH = 2'b11);
  - the irq_line_t struct shared with the register file;
  - the cand_t struct {valid, id, prio};
  - the FSM state enum.
- One sub-module, hetic_prio_tree: a parameterized combinational max-tree with tie-break to the lower index. The FSM, edge detect and registers stay in hetic_arbiter.

Test Plan:
- Line 5, ie = 1, trig = 01, prio = 3, threshold = 0. Pulse src[5] 0->1 -> ip_set_o[5] = 1 for one cycle. With cfg_ip then driven high, irq_valid_o is high 2 cycles later with id = 5, prio = 3.
- Lines 2 and 9 pending with equal prio 4 -> id = 2 is presented. Lines 2 (prio 4) and 9 (prio 7) pending -> id = 9 is presented.
- In REQ with id = 9, prio = 7:
  - ack with id 3 -> ignored, irq_valid_o stays 1;
  - ack with id 9 -> ip_clr_o[9] pulses once, irq_valid_o is 0 for 2 cycles, then line 2 is presented.
- In REQ with id = 2, prio = 4, line 11 becomes pending at prio 6 -> id switches to 11 with no ip_clr_o pulse. A same-cycle ack of id 2 instead -> line 2 is cleared and there is no pre-emption.
- threshold_i raised from 0 to 7 while presenting prio 5 -> irq_valid_o falls within 2 cycles. Prio-0 lines are never presented.
- Level-triggered line held high and acked -> ip_set_o and ip_clr_o are both asserted in the ack cycle, and the line is re-presented after SETTLE. Asserting rst_i mid-REQ -> all outputs are 0 immediately.

Source files
------------

// File: rtl/hetic_pkg.sv
// Shared types for the HETI interrupt scheduler: trigger modes, line config,
// arbitration candidates and the presentation FSM states.
package hetic_pkg;

  localparam int unsigned NrIrqLines = 64;
  localparam int unsigned NrIrqPrios = 32;
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);

  typedef enum logic [1:0] {
    LEVEL = 2'b00,
    RISE  = 2'b01,
    FALL  = 2'b10,
    BOTH  = 2'b11
  } trig_e;

  typedef struct packed {
    logic                 ie;
    logic                 ip;
    trig_e                trig;
    logic                 heti;
    logic                 nest;
    logic [PrioWidth-1:0] prio;
  } irq_line_t;

  typedef struct packed {
    logic                 valid;
    logic [IrqWidth-1:0]  id;
    logic [PrioWidth-1:0] prio;
  } cand_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    SETTLE = 2'b10
  } state_e;

  // Pending-set request for one line given its trigger mode.
  function automatic logic edge_set(trig_e trig, logic src, logic src_q);
    logic set;
    unique case (trig)
      LEVEL:   set = src;
      RISE:    set = src & ~src_q;
      FALL:    set = ~src & src_q;
      default: set = src ^ src_q;
    endcase
    return set;
  endfunction

  // lo covers the lower indices, so it keeps ties.
  function automatic cand_t cand_pick(cand_t lo, cand_t hi);
    return (hi.valid && (!lo.valid || (hi.prio > lo.prio))) ? hi : lo;
  endfunction

endpackage

// File: rtl/hetic_prio_tree.sv
// Combinational max-priority tournament over NumIn candidates; ties go to
// the lower index.
module hetic_prio_tree
  import hetic_pkg::*;
#(
  parameter int unsigned NumIn = NrIrqLines
) (
  input  logic [NumIn-1:0]                valid_i,
  input  logic [NumIn-1:0][PrioWidth-1:0] prio_i,
  output cand_t                           best_o
);

  localparam int unsigned NumLvl = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned NumPad = 1 << NumLvl;

  logic [NumPad-1:0]                valid_pad;
  logic [NumPad-1:0][PrioWidth-1:0] prio_pad;

  assign valid_pad = NumPad'(valid_i);
  assign prio_pad  = (NumPad*PrioWidth)'(prio_i);

  // Heap-ordered tree: leaves at NumPad-1.., children of k at 2k+1 / 2k+2.
  function automatic cand_t tree_max(logic [NumPad-1:0]                v,
                                     logic [NumPad-1:0][PrioWidth-1:0] p);
    cand_t node [2*NumPad-1];
    for (int i = 0; i < int'(NumPad); i++) begin
      if (v[i]) node[int'(NumPad)-1+i] = '{1'b1, IrqWidth'(i), p[i]};
      else      node[int'(NumPad)-1+i] = '0;
    end
    for (int k = int'(NumPad)-2; k >= 0; k--) begin
      node[k] = cand_pick(node[2*k+1], node[2*k+2]);
    end
    return node[0];
  endfunction

  assign best_o = tree_max(valid_pad, prio_pad);

endmodule

// File: rtl/hetic_arbiter.sv
// HETI interrupt scheduler: trigger-mode pending sets, priority selection
// above threshold, presentation to the core and pending-clear on acknowledge.
module hetic_arbiter
  import hetic_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrIrqLines-1:0]           irq_src_i,
  input  logic [NrIrqLines-1:0]           cfg_ie_i,
  input  logic [NrIrqLines-1:0]           cfg_ip_i,
  input  logic [2*NrIrqLines-1:0]         cfg_trig_i,
  input  logic [NrIrqLines-1:0]           cfg_heti_i,
  input  logic [NrIrqLines-1:0]           cfg_nest_i,
  input  logic [PrioWidth*NrIrqLines-1:0] cfg_prio_i,
  input  logic [PrioWidth-1:0]            threshold_i,
  output logic [NrIrqLines-1:0]           ip_set_o,
  output logic [NrIrqLines-1:0]           ip_clr_o,
  output logic                            irq_valid_o,
  output logic [IrqWidth-1:0]             irq_id_o,
  output logic [PrioWidth-1:0]            irq_prio_o,
  output logic                            irq_heti_o,
  output logic                            irq_nest_o,
  input  logic                            irq_ack_i,
  input  logic [IrqWidth-1:0]             irq_ack_id_i
);

  irq_line_t [NrIrqLines-1:0]            line;
  logic [NrIrqLines-1:0]                 src_q;
  logic [NrIrqLines-1:0]                 set_vec;
  logic [NrIrqLines-1:0]                 cand_vec;
  logic [NrIrqLines-1:0]                 clr_vec;
  logic [NrIrqLines-1:0][PrioWidth-1:0]  prio_vec;

  cand_t                best_d, best_q;
  state_e               state_d, state_q;
  logic                 valid_d, valid_q;
  logic [IrqWidth-1:0]  id_d, id_q;
  logic [PrioWidth-1:0] prio_d, prio_q;
  logic                 heti_d, heti_q;
  logic                 nest_d, nest_q;
  logic                 latch;

  for (genvar g = 0; g < NrIrqLines; g++) begin : g_line
    assign line[g] = '{cfg_ie_i[g], cfg_ip_i[g], trig_e'(cfg_trig_i[2*g +: 2]),
                       cfg_heti_i[g], cfg_nest_i[g],
                       cfg_prio_i[PrioWidth*g +: PrioWidth]};
    assign set_vec[g]  = edge_set(line[g].trig, irq_src_i[g], src_q[g]);
    // Priority 0 can never exceed any threshold, so it is never a candidate.
    assign cand_vec[g] = line[g].ie & line[g].ip & (line[g].prio > threshold_i);
    assign prio_vec[g] = line[g].prio;
  end

  hetic_prio_tree #(
    .NumIn (NrIrqLines)
  ) u_tree (
    .valid_i (cand_vec),
    .prio_i  (prio_vec),
    .best_o  (best_d)
  );

  // Presentation FSM; valid stays low through SETTLE and the following IDLE
  // cycle so a cleared pending bit has reached best_q before re-arbitration.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    prio_d  = prio_q;
    heti_d  = heti_q;
    nest_d  = nest_q;
    clr_vec = '0;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (best_q.valid) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i && (irq_ack_id_i == id_q)) begin
          clr_vec[id_q] = 1'b1;
          state_d       = SETTLE;
          valid_d       = 1'b0;
        end else if (best_q.valid && (best_q.prio > prio_q)) begin
          latch = 1'b1;
        end else if (!best_q.valid) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      SETTLE: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (latch) begin
      valid_d = 1'b1;
      id_d    = best_q.id;
      prio_d  = best_q.prio;
      heti_d  = line[best_q.id].heti;
      nest_d  = line[best_q.id].nest;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q   <= '0;
      best_q  <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
      heti_q  <= 1'b0;
      nest_q  <= 1'b0;
    end else begin
      src_q   <= irq_src_i;
      best_q  <= best_d;
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      heti_q  <= heti_d;
      nest_q  <= nest_d;
    end
  end

  // Level sources may still be high during reset; keep the strobes quiet.
  assign ip_set_o    = rst_i ? '0 : set_vec;
  assign ip_clr_o    = clr_vec;
  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_prio_o  = prio_q;
  assign irq_heti_o  = heti_q;
  assign irq_nest_o  = nest_q;

endmodule

// File: tb/tb_hetic_arbiter.sv
// Directed bench for hetic_arbiter with a small pending-register model that
// applies set-priority resolution of ip_set_o / ip_clr_o.
module tb_hetic_arbiter;
  import hetic_pkg::*;

  logic                            clk;
  logic                            rst;
  logic [NrIrqLines-1:0]           irq_src;
  logic [NrIrqLines-1:0]           cfg_ie;
  logic [NrIrqLines-1:0]           cfg_ip;
  logic [2*NrIrqLines-1:0]         cfg_trig;
  logic [NrIrqLines-1:0]           cfg_heti;
  logic [NrIrqLines-1:0]           cfg_nest;
  logic [PrioWidth*NrIrqLines-1:0] cfg_prio;
  logic [PrioWidth-1:0]            threshold;
  logic [NrIrqLines-1:0]           ip_set;
  logic [NrIrqLines-1:0]           ip_clr;
  logic                            irq_valid;
  logic [IrqWidth-1:0]             irq_id;
  logic [PrioWidth-1:0]            irq_prio;
  logic                            irq_heti;
  logic                            irq_nest;
  logic                            ack;
  logic [IrqWidth-1:0]             ack_id;
  logic [NrIrqLines-1:0]           sw_set;
  logic [NrIrqLines-1:0]           sw_clr;

  int n_vec;
  int n_err;

  hetic_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_src_i    (irq_src),
    .cfg_ie_i     (cfg_ie),
    .cfg_ip_i     (cfg_ip),
    .cfg_trig_i   (cfg_trig),
    .cfg_heti_i   (cfg_heti),
    .cfg_nest_i   (cfg_nest),
    .cfg_prio_i   (cfg_prio),
    .threshold_i  (threshold),
    .ip_set_o     (ip_set),
    .ip_clr_o     (ip_clr),
    .irq_valid_o  (irq_valid),
    .irq_id_o     (irq_id),
    .irq_prio_o   (irq_prio),
    .irq_heti_o   (irq_heti),
    .irq_nest_o   (irq_nest),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file pending bits: set wins over clear.
  always @(posedge clk or posedge rst) begin
    if (rst) cfg_ip <= '0;
    else     cfg_ip <= (((cfg_ip | sw_set) & ~sw_clr) & ~ip_clr) | ip_set;
  end

  task automatic do_reset();
    rst = 1'b1;
    irq_src = '0; cfg_ie = '0; cfg_trig = '0; cfg_heti = '0; cfg_nest = '0;
    cfg_prio = '0; threshold = '0; ack = 1'b0; ack_id = '0;
    sw_set = '0; sw_clr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_line(input int i, input logic ie, input trig_e t,
                          input int p, input logic h, input logic n);
    cfg_ie[i] = ie;
    cfg_trig[2*i +: 2] = t;
    cfg_prio[PrioWidth*i +: PrioWidth] = PrioWidth'(p);
    cfg_heti[i] = h;
    cfg_nest[i] = n;
  endtask

  task automatic pend(input logic [NrIrqLines-1:0] m);
    sw_set = m;
    @(negedge clk);
    sw_set = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    irq_src = '1; cfg_ie = '0; cfg_trig = '0; cfg_heti = '0; cfg_nest = '0;
    cfg_prio = '0; threshold = '0; ack = 1'b0; ack_id = '0;
    sw_set = '0; sw_clr = '0;
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b0 || irq_id !== '0 || irq_prio !== '0 || irq_heti !== 1'b0 ||
        irq_nest !== 1'b0 || ip_set !== '0 || ip_clr !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b id=%0d prio=%0d set=%h clr=%h, want all 0",
               irq_valid, irq_id, irq_prio, ip_set, ip_clr);
    end
    irq_src = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_edges();
    logic [NrIrqLines-1:0] exp;
    do_reset();
    set_line(1, 1'b0, FALL, 1, 1'b0, 1'b0);
    set_line(3, 1'b0, BOTH, 1, 1'b0, 1'b0);
    irq_src[1] = 1'b1; irq_src[3] = 1'b1;
    #1;
    exp = '0; exp[3] = 1'b1;
    n_vec++;
    if (ip_set !== exp) begin
      n_err++; $display("FAIL edge_rise_both: set=%h want %h", ip_set, exp);
    end
    @(negedge clk); #1;
    n_vec++;
    if (ip_set !== '0) begin
      n_err++; $display("FAIL edge_hold_high: set=%h want 0", ip_set);
    end
    irq_src[1] = 1'b0; irq_src[3] = 1'b0;
    #1;
    exp = '0; exp[1] = 1'b1; exp[3] = 1'b1;
    n_vec++;
    if (ip_set !== exp) begin
      n_err++; $display("FAIL edge_fall_both: set=%h want %h", ip_set, exp);
    end
  endtask

  task automatic test_rise_present();
    logic [NrIrqLines-1:0] exp;
    do_reset();
    set_line(5, 1'b1, RISE, 3, 1'b0, 1'b0);
    irq_src[5] = 1'b1;
    #1;
    exp = '0; exp[5] = 1'b1;
    n_vec++;
    if (ip_set !== exp) begin
      n_err++; $display("FAIL rise_strobe: set=%h want %h", ip_set, exp);
    end
    @(negedge clk); #1;
    n_vec++;
    if (ip_set !== '0 || irq_valid !== 1'b0) begin
      n_err++; $display("FAIL rise_one_cycle: set=%h valid=%b want 0/0", ip_set, irq_valid);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b0) begin
      n_err++; $display("FAIL rise_latency_early: valid=%b want 0", irq_valid);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd5 || irq_prio !== 5'd3) begin
      n_err++; $display("FAIL rise_present: valid=%b id=%0d prio=%0d want 1/5/3",
                        irq_valid, irq_id, irq_prio);
    end
    ack = 1'b1; ack_id = 6'd5;
    #1;
    n_vec++;
    if (ip_clr !== exp) begin
      n_err++; $display("FAIL rise_ack_clr: clr=%h want %h", ip_clr, exp);
    end
    @(negedge clk);
    ack = 1'b0;
    irq_src[5] = 1'b0;
  endtask

  task automatic test_tie_and_preempt_by_prio();
    logic [NrIrqLines-1:0] m;
    do_reset();
    set_line(2, 1'b1, LEVEL, 4, 1'b0, 1'b0);
    set_line(9, 1'b1, LEVEL, 4, 1'b0, 1'b0);
    m = '0; m[2] = 1'b1; m[9] = 1'b1;
    pend(m);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd2 || irq_prio !== 5'd4) begin
      n_err++; $display("FAIL tie_low_index: valid=%b id=%0d prio=%0d want 1/2/4",
                        irq_valid, irq_id, irq_prio);
    end
    cfg_prio[PrioWidth*9 +: PrioWidth] = 5'd7;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd9 || irq_prio !== 5'd7) begin
      n_err++; $display("FAIL higher_prio_wins: valid=%b id=%0d prio=%0d want 1/9/7",
                        irq_valid, irq_id, irq_prio);
    end
  endtask

  task automatic test_ack();
    logic [NrIrqLines-1:0] exp;
    ack = 1'b1; ack_id = 6'd3;
    #1;
    n_vec++;
    if (ip_clr !== '0) begin
      n_err++; $display("FAIL ack_wrong_id_clr: clr=%h want 0", ip_clr);
    end
    @(negedge clk);
    ack = 1'b0;
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd9) begin
      n_err++; $display("FAIL ack_wrong_id_hold: valid=%b id=%0d want 1/9", irq_valid, irq_id);
    end
    ack = 1'b1; ack_id = 6'd9;
    #1;
    exp = '0; exp[9] = 1'b1;
    n_vec++;
    if (ip_clr !== exp) begin
      n_err++; $display("FAIL ack_clr_pulse: clr=%h want %h", ip_clr, exp);
    end
    @(negedge clk);
    ack = 1'b0;
    #1;
    n_vec++;
    if (irq_valid !== 1'b0 || ip_clr !== '0) begin
      n_err++; $display("FAIL settle_1: valid=%b clr=%h want 0/0", irq_valid, ip_clr);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b0) begin
      n_err++; $display("FAIL settle_2: valid=%b want 0", irq_valid);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd2 || irq_prio !== 5'd4) begin
      n_err++; $display("FAIL after_settle: valid=%b id=%0d prio=%0d want 1/2/4",
                        irq_valid, irq_id, irq_prio);
    end
  endtask

  task automatic test_preempt();
    logic [NrIrqLines-1:0] m;
    set_line(11, 1'b1, LEVEL, 6, 1'b0, 1'b0);
    m = '0; m[11] = 1'b1;
    pend(m);
    @(negedge clk);
    n_vec++;
    if (irq_id !== 6'd2 || ip_clr !== '0) begin
      n_err++; $display("FAIL preempt_not_yet: id=%0d clr=%h want 2/0", irq_id, ip_clr);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd11 || irq_prio !== 5'd6 || ip_clr !== '0) begin
      n_err++; $display("FAIL preempt_switch: valid=%b id=%0d prio=%0d clr=%h want 1/11/6/0",
                        irq_valid, irq_id, irq_prio, ip_clr);
    end
    // Retire line 11 so line 2 is back on display.
    ack = 1'b1; ack_id = 6'd11;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd2) begin
      n_err++; $display("FAIL preempt_return: valid=%b id=%0d want 1/2", irq_valid, irq_id);
    end
    pend(m);
    @(negedge clk);
    ack = 1'b1; ack_id = 6'd2;
    #1;
    m = '0; m[2] = 1'b1;
    n_vec++;
    if (ip_clr !== m) begin
      n_err++; $display("FAIL ack_vs_preempt_clr: clr=%h want %h", ip_clr, m);
    end
    @(negedge clk);
    ack = 1'b0;
    n_vec++;
    if (irq_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_beats_preempt: valid=%b id=%0d want valid 0", irq_valid, irq_id);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd11 || irq_prio !== 5'd6) begin
      n_err++; $display("FAIL ack_then_next: valid=%b id=%0d prio=%0d want 1/11/6",
                        irq_valid, irq_id, irq_prio);
    end
  endtask

  task automatic test_threshold_attr();
    logic [NrIrqLines-1:0] m;
    do_reset();
    set_line(4, 1'b1, LEVEL, 5, 1'b1, 1'b0);
    set_line(6, 1'b1, LEVEL, 0, 1'b1, 1'b1);
    m = '0; m[4] = 1'b1; m[6] = 1'b1;
    pend(m);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd4 || irq_prio !== 5'd5 ||
        irq_heti !== 1'b1 || irq_nest !== 1'b0) begin
      n_err++; $display("FAIL attr_present: valid=%b id=%0d prio=%0d heti=%b nest=%b want 1/4/5/1/0",
                        irq_valid, irq_id, irq_prio, irq_heti, irq_nest);
    end
    cfg_heti[4] = 1'b0; cfg_nest[4] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_heti !== 1'b1 || irq_nest !== 1'b0) begin
      n_err++; $display("FAIL attr_stable: valid=%b heti=%b nest=%b want 1/1/0",
                        irq_valid, irq_heti, irq_nest);
    end
    threshold = 5'd7;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b0) begin
      n_err++; $display("FAIL threshold_drop: valid=%b want 0", irq_valid);
    end
    m = '0; m[4] = 1'b1;
    sw_clr = m;
    @(negedge clk);
    sw_clr = '0;
    threshold = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (irq_valid !== 1'b0) begin
        n_err++; $display("FAIL prio0_never: cycle %0d valid=%b id=%0d want 0", c, irq_valid, irq_id);
      end
    end
  endtask

  task automatic test_level_reack_reset();
    logic [NrIrqLines-1:0] m;
    do_reset();
    set_line(7, 1'b1, LEVEL, 2, 1'b0, 1'b1);
    irq_src[7] = 1'b1;
    #1;
    m = '0; m[7] = 1'b1;
    n_vec++;
    if (ip_set !== m) begin
      n_err++; $display("FAIL level_set: set=%h want %h", ip_set, m);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd7 || irq_prio !== 5'd2 || irq_nest !== 1'b1) begin
      n_err++; $display("FAIL level_present: valid=%b id=%0d prio=%0d nest=%b want 1/7/2/1",
                        irq_valid, irq_id, irq_prio, irq_nest);
    end
    ack = 1'b1; ack_id = 6'd7;
    #1;
    n_vec++;
    if (ip_set !== m || ip_clr !== m) begin
      n_err++; $display("FAIL level_set_and_clr: set=%h clr=%h want %h/%h", ip_set, ip_clr, m, m);
    end
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b0) begin
      n_err++; $display("FAIL level_settle: valid=%b want 0", irq_valid);
    end
    @(negedge clk);
    n_vec++;
    if (irq_valid !== 1'b1 || irq_id !== 6'd7) begin
      n_err++; $display("FAIL level_repend: valid=%b id=%0d want 1/7", irq_valid, irq_id);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (irq_valid !== 1'b0 || irq_id !== '0 || irq_prio !== '0 || irq_nest !== 1'b0 ||
        ip_set !== '0 || ip_clr !== '0) begin
      n_err++; $display("FAIL async_reset: valid=%b id=%0d prio=%0d set=%h clr=%h want all 0",
                        irq_valid, irq_id, irq_prio, ip_set, ip_clr);
    end
    @(negedge clk);
    irq_src = '0;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    test_reset();
    test_edges();
    test_rise_present();
    test_tie_and_preempt_by_prio();
    test_ack();
    test_preempt();
    test_threshold_attr();
    test_level_reack_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion within 200000 time units");
    $fatal(1);
  end

endmodule
